// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host-side queue port of the UART transmitter.
//   tx_data     byte to queue (host -> tx)
//   tx_wr       write strobe; accepted when tx_full=0 (host -> tx)
//   tx_full     FIFO is full (tx -> host)
//   tx_busy     FIFO non-empty or a frame in flight (tx -> host)
//   tx_overflow sticky rejected-write flag (tx -> host)
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_full;
    logic       tx_busy;
    logic       tx_overflow;
    modport master(output tx_data, tx_wr, input tx_full, tx_busy, tx_overflow);
    modport slave(input tx_data, tx_wr, output tx_full, tx_busy, tx_overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter, LSB first, frames sent back to back.
//   clk     system clock, rising edge
//   reset   asynchronous active-high reset
//   ck_en   bit-rate strobe shared with uart_rx; CK_PER_BIT pulses per serial bit
//   bus     slave side of uart_tx_fifo_if (tx_data/tx_wr in; tx_full/tx_busy/tx_overflow out)
//   tx_pin  registered serial output, idle high
module uart_tx_fifo #(
    parameter int CK_PER_BIT = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ck_en,
    uart_tx_fifo_if.slave  bus,
    output logic           tx_pin
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [7:0]         bit_cnt;
    logic [2:0]         idx;
    logic [7:0]         shift_reg;
    logic               busy, overflow;
    logic               full, wr_ok, bit_done, pop;

    // Full is taken from the pre-pop count so a write racing a pop is still rejected.
    assign full     = count == (FIFO_AW+1)'(DEPTH);
    assign wr_ok    = bus.tx_wr & ~full;
    assign bit_done = bit_cnt == 8'(CK_PER_BIT - 1);
    // Pops only happen on ck_en, so every frame starts aligned to the bit-rate strobe.
    assign pop      = ck_en & (count != '0) & ((state == IDLE) | ((state == STOP) & bit_done));

    assign bus.tx_full     = full;
    assign bus.tx_busy     = busy;
    assign bus.tx_overflow = overflow;

    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr] <= bus.tx_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
            bit_cnt   <= '0;
            idx       <= '0;
            shift_reg <= '0;
            tx_pin    <= 1'b1;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (FIFO_AW+1)'(wr_ok) - (FIFO_AW+1)'(pop);
            if (bus.tx_wr && full) overflow <= 1'b1;
            busy <= (state != IDLE) | (count != '0);
            if (ck_en) begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            shift_reg <= mem[rd_ptr];
                            tx_pin    <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= START;
                        end
                    end
                    START: begin
                        bit_cnt <= bit_done ? '0 : bit_cnt + 8'd1;
                        if (bit_done) begin
                            idx    <= '0;
                            tx_pin <= shift_reg[0];
                            state  <= DATA;
                        end
                    end
                    DATA: begin
                        bit_cnt <= bit_done ? '0 : bit_cnt + 8'd1;
                        if (bit_done && idx == 3'd7) begin
                            tx_pin <= 1'b1;
                            state  <= STOP;
                        end else if (bit_done) begin
                            idx       <= idx + 3'd1;
                            shift_reg <= shift_reg >> 1;
                            tx_pin    <= shift_reg[1];
                        end
                    end
                    default: begin
                        bit_cnt <= bit_done ? '0 : bit_cnt + 8'd1;
                        // Chain straight into the next start bit when more bytes are queued.
                        if (pop) begin
                            shift_reg <= mem[rd_ptr];
                            tx_pin    <= 1'b0;
                            state     <= START;
                        end else if (bit_done) begin
                            state <= IDLE;
                        end
                    end
                endcase
            end
        end
    end
endmodule
